sisc_ifetch: RTL and testbench

//  Instruction fetch/issue unit that produces the 32-bit IR consumed by the sisc core.

---
 rtl/sisc_ifetch_pkg.sv | 24 ++
 rtl/sisc_ifetch_wdt.sv | 40 ++++
 rtl/sisc_ifetch.sv | 116 +++++++++++
 tb/tb_sisc_ifetch.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sisc_ifetch_pkg.sv
// Shared definitions for the sisc instruction-fetch unit: opcodes, state encodings, defaults.
`default_nettype none

package sisc_ifetch_pkg;

  localparam int AW_DEFAULT = 16;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_ISSUE = 2'd2,
    IF_HALT  = 2'd3
  } if_state_e;

  function automatic logic is_hlt(input logic [31:0] instr);
    return instr[31:28] == OP_HLT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sisc_ifetch_wdt.sv
// Fetch watchdog: counts cycles waiting on imem_ack and flags the cycle the count reaches TIMEOUT.
`default_nettype none

module sisc_ifetch_wdt #(
  parameter int TIMEOUT = 15
) (
  input  logic CLK,
  input  logic RST_F,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (en_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is flagged in the waiting cycle whose increment would reach TIMEOUT,
  // so the owner can still let a same-cycle ack win.
  assign expired_o = (count_q == 8'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/sisc_ifetch.sv
// Instruction fetch/issue unit: owns the PC, fetches from imem, holds IR until the core consumes it.
`default_nettype none

module sisc_ifetch
  import sisc_ifetch_pkg::*;
#(
  parameter int            AW       = AW_DEFAULT,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            TIMEOUT  = 15
) (
  input  logic          CLK,
  input  logic          RST_F,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_ack,
  input  logic          next_instr,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic [31:0]   IR,
  output logic          ir_valid,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          fetch_err
);

  if_state_e     state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic          halted_q, halted_d;
  logic          err_q, err_d;
  logic          wdt_clr, wdt_en, wdt_expired;

  sisc_ifetch_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .CLK       (CLK),
    .RST_F     (RST_F),
    .clr_i     (wdt_clr),
    .en_i      (wdt_en),
    .expired_o (wdt_expired)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    err_d      = err_q;
    wdt_clr    = 1'b1;
    wdt_en     = 1'b0;
    case (state_q)
      IF_IDLE: state_d = IF_FETCH;
      IF_FETCH: begin
        wdt_clr = 1'b0;
        if (imem_ack) begin
          ir_d       = imem_rdata;
          ir_valid_d = 1'b1;
          wdt_clr    = 1'b1;
          state_d    = IF_ISSUE;
        end else begin
          wdt_en = 1'b1;
          if (wdt_expired) begin
            err_d    = 1'b1;
            halted_d = 1'b1;
            state_d  = IF_HALT;
          end
        end
      end
      IF_ISSUE: begin
        if (next_instr) begin
          ir_valid_d = 1'b0;
          if (is_hlt(ir_q)) begin
            halted_d = 1'b1;
            state_d  = IF_HALT;
          end else begin
            pc_d    = br_taken ? br_target : pc_q + AW'(1);
            state_d = IF_FETCH;
          end
        end
      end
      default: state_d = IF_HALT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state_q    <= IF_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= {OP_NOP, 28'h0};
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  assign imem_req  = (state_q == IF_FETCH);
  assign imem_addr = pc_q;
  assign IR        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign fetch_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sisc_ifetch.sv
// Directed self-checking bench for sisc_ifetch (AW=16, RESET_PC=0, TIMEOUT=15).
`default_nettype none

module tb_sisc_ifetch;

  localparam int AW = 16;

  logic          CLK = 1'b0;
  logic          RST_F = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = '0;
  logic          imem_ack = 1'b0;
  logic          next_instr = 1'b0;
  logic          br_taken = 1'b0;
  logic [AW-1:0] br_target = '0;
  logic [31:0]   IR;
  logic          ir_valid;
  logic [AW-1:0] pc;
  logic          halted;
  logic          fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  sisc_ifetch #(
    .AW       (AW),
    .RESET_PC (16'h0000),
    .TIMEOUT  (15)
  ) dut (
    .CLK        (CLK),
    .RST_F      (RST_F),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .next_instr (next_instr),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .IR         (IR),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .halted     (halted),
    .fetch_err  (fetch_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the DUT in its first FETCH cycle, 1 time unit after the edge.
  task automatic do_reset();
    RST_F = 1'b0;
    imem_ack = 1'b0;
    next_instr = 1'b0;
    br_taken = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_ir", IR, 32'h0);
    check("rst_irv", {31'b0, ir_valid}, 32'd0);
    check("rst_pc", {16'b0, pc}, 32'd0);
    check("rst_flags", {30'b0, halted, fetch_err}, 32'd0);
    @(negedge CLK);
    RST_F = 1'b1;
    step();
  endtask

  task automatic issue_one(input logic [AW-1:0] exp_addr, input logic [31:0] data, input int delay);
    logic [31:0] ir_prev;
    ir_prev = IR;
    check("fetch_req", {31'b0, imem_req}, 32'd1);
    check("fetch_addr", {16'b0, imem_addr}, {16'b0, exp_addr});
    check("fetch_irv", {31'b0, ir_valid}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      step();
      check("wait_req", {31'b0, imem_req}, 32'd1);
      check("wait_addr", {16'b0, imem_addr}, {16'b0, exp_addr});
      check("wait_ir", IR, ir_prev);
      check("wait_err", {31'b0, fetch_err}, 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    step();
    imem_ack = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check("issue_ir", IR, data);
    check("issue_irv", {31'b0, ir_valid}, 32'd1);
    check("issue_req", {31'b0, imem_req}, 32'd0);
  endtask

  task automatic consume(input logic br, input logic [AW-1:0] tgt);
    next_instr = 1'b1;
    br_taken = br;
    br_target = tgt;
    step();
    next_instr = 1'b0;
    br_taken = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Sequential fetch with single-cycle memory.
    do_reset();
    issue_one(16'h0000, 32'h1123_0000, 0);
    consume(1'b0, '0);
    issue_one(16'h0001, 32'h1234_0000, 0);
    consume(1'b0, '0);
    check("seq_addr2", {16'b0, imem_addr}, 32'h2);

    // Branch: reach pc=5, then br_taken alone must not move pc.
    issue_one(16'h0002, 32'h1000_0002, 0);
    consume(1'b1, 16'h0005);
    issue_one(16'h0005, 32'h2000_0005, 0);
    br_taken = 1'b1;
    br_target = 16'h0077;
    step();
    br_taken = 1'b0;
    check("br_hold_pc", {16'b0, pc}, 32'h5);
    check("br_hold_irv", {31'b0, ir_valid}, 32'd1);
    consume(1'b1, 16'h0040);
    check("br_addr", {16'b0, imem_addr}, 32'h40);

    // Slow memory: ack in the 4th FETCH cycle.
    issue_one(16'h0040, 32'h3000_0040, 3);
    check("slow_err", {31'b0, fetch_err}, 32'd0);
    consume(1'b0, '0);

    // Asynchronous reset while a fetch is outstanding.
    check("mid_req", {31'b0, imem_req}, 32'd1);
    RST_F = 1'b0;
    #1;
    check("async_req", {31'b0, imem_req}, 32'd0);
    check("async_pc", {16'b0, pc}, 32'd0);
    check("async_irv", {31'b0, ir_valid}, 32'd0);
    do_reset();
    issue_one(16'h0000, 32'h1123_0000, 0);

    // HLT consumed: halted, pc frozen, stays there.
    consume(1'b0, '0);
    issue_one(16'h0001, 32'hF000_0000, 0);
    consume(1'b0, '0);
    check("hlt_halted", {31'b0, halted}, 32'd1);
    check("hlt_irv", {31'b0, ir_valid}, 32'd0);
    next_instr = 1'b1;
    repeat (3) step();
    next_instr = 1'b0;
    check("hlt_pc", {16'b0, pc}, 32'h1);
    check("hlt_req", {31'b0, imem_req}, 32'd0);
    check("hlt_ir", IR, 32'hF000_0000);
    check("hlt_err", {31'b0, fetch_err}, 32'd0);

    // PC wrap from 0xFFFF.
    do_reset();
    issue_one(16'h0000, 32'h1123_0000, 0);
    consume(1'b1, 16'hFFFF);
    issue_one(16'hFFFF, 32'h1000_FFFF, 0);
    consume(1'b0, '0);
    check("wrap_pc", {16'b0, pc}, 32'h0);
    check("wrap_req", {31'b0, imem_req}, 32'd1);

    // Timeout: no ack for 15 FETCH cycles.
    do_reset();
    for (int i = 0; i < 14; i++) step();
    check("to_pre_err", {31'b0, fetch_err}, 32'd0);
    check("to_pre_req", {31'b0, imem_req}, 32'd1);
    step();
    check("to_err", {31'b0, fetch_err}, 32'd1);
    check("to_halted", {31'b0, halted}, 32'd1);
    step();
    check("to_req", {31'b0, imem_req}, 32'd0);

    // Ack in exactly the 15th FETCH cycle still wins.
    do_reset();
    for (int i = 0; i < 14; i++) step();
    imem_ack = 1'b1;
    imem_rdata = 32'h5555_0000;
    step();
    imem_ack = 1'b0;
    check("late_err", {31'b0, fetch_err}, 32'd0);
    check("late_halted", {31'b0, halted}, 32'd0);
    check("late_ir", IR, 32'h5555_0000);
    check("late_irv", {31'b0, ir_valid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
